uart_result_reporter: RTL and testbench
=======================================

Name: uart_result_reporter

Overview:
- Sits directly downstream of the processor's 32-bit `led` result output.
- Detects each change of that word, buffers it in a small FIFO, and serialises it over a UART TX line as 8 uppercase ASCII hex digits plus a separator.
- Lets a host terminal capture the processor's result stream without a logic analyser.

Parameters:
- CLK_DIV, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥2.
- FIFO_DEPTH, 16: word entries; power of two, ≥2.
- DROP_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted.
- val  in  32  result word from the processor (`led`), sampled every cycle.
- txd  out  1  UART serial output, 8N1, idle high.
- busy  out  1  1 while the FIFO is non-empty or a frame is in progress.
- level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  DROP_W  number of words lost to a full FIFO; saturates.

Behaviour:
- Reset (rst=0, asynchronous):
  - txd=1, busy=0, level=0, drop_cnt=0.
  - FIFO emptied, prev=0, FSM forced to IDLE.
  - Takes effect immediately, including mid-character; no partial frame resumes after release.
- Change detection:
  - Register prev holds the last observed val.
  - At each edge where val != prev: prev <= val and a push of val is requested.
  - Consequence: val=0 after reset is never reported; a repeated value is never reported.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than log2(FIFO_DEPTH); wrap-around is via pointer overflow.
  - Full = MSBs differ and remaining bits equal. Empty = pointers equal.
  - A push request while full is dropped and drop_cnt increments, holding at 2^DROP_W-1.
  - Full is evaluated before any pop in the same cycle, so a push to a full FIFO is dropped even if a pop occurs that edge.
  - Push and pop on the same edge with the FIFO not full: both occur; level is unchanged.
- Transmit FSM, states IDLE, START, DATA, STOP:
  - IDLE: txd=1. If the FIFO is non-empty at an edge, pop the word into a shift word, set char index=0, form the first character, go to START.
  - START: txd=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, each held CLK_DIV cycles; a 3-bit counter selects the bit.
  - STOP: txd=1 for CLK_DIV cycles. Then:
    - if more characters remain in the word, go to START with the next character (no idle gap);
    - else, if the FIFO is non-empty, pop and go to START;
    - else go to IDLE.
  - Frame = 10·CLK_DIV cycles. The baud counter runs 0..CLK_DIV-1 and resets on each state/bit change.
- Character order: nibbles [31:28] down to [3:0], then separator(s).
  - Digit encoding: 0–9 → 0x30–0x39; A–F → 0x41–0x46.
- Latency: val changes before edge n → pushed at edge n → popped at edge n+1 (if idle) → txd falls after edge n+1.
- busy = (level != 0) || (state != IDLE). Registered outputs change only on clk edges.

Optional Feature:
- RPT_CRLF_EN defined: each word is followed by 0x0D, 0x0A, giving 10 characters per word.
- RPT_CRLF_EN undefined: each word is followed by a single 0x20, giving 9 characters per word.
- Character-count terminal value is chosen at compile time; all other behaviour is identical.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4, DROP_W=4 unless noted):
1. Hold rst=0 for 3 cycles, then release with val=0 for 100 cycles → txd=1 throughout, busy=0, level=0, drop_cnt=0.
2. With RPT_CRLF_EN, val 0→0x12345678 held → txd falls one edge after the push; decoded bytes are "12345678\r\n"; each bit is 4 cycles; busy=0 exactly 400 cycles after the first start bit.
3. Without RPT_CRLF_EN, val=0xDEADBEEF then 0x0000000F → decoded "DEADBEEF 0000000F "; level peaks at 1.
4. val stepping 1,2,3,… on every cycle for 30 cycles:
   - 1 word popped immediately, 4 fill the FIFO, 25 dropped → drop_cnt=15 (saturated).
   - Output is words 1–5 in order.
5. Assert rst=0 mid-DATA of the 3rd character → txd=1 combinationally within the same cycle; after release no further bytes, level=0, drop_cnt=0.
6. Push while full on the same edge as a pop (STOP→START of the next word) → the pushed word is dropped, drop_cnt increments by 1, level = FIFO_DEPTH-1 afterwards.

Source files
------------

// File: rtl/uart_result_reporter.sv
// Watches the processor result word, queues every change and prints it over UART 8N1
// as 8 uppercase hex digits plus a separator (" " by default, CR LF when RPT_CRLF_EN is defined).
module uart_result_reporter #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   val,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [DROP_W-1:0]             drop_cnt,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
`ifdef RPT_CRLF_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd8;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [31:0]       r_prev;
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [DROP_W-1:0] r_drop;
  logic [BW-1:0]     r_baud;
  logic [2:0]        r_bit;
  logic [3:0]        r_char_idx;
  logic [31:0]       r_word;
  logic [7:0]        w_char;
  logic              w_push_req;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_baud_done;
  logic              w_last_char;
  logic              w_pop;
  logic              w_next_char;
  logic              w_txd;

  assign w_push_req  = (val != r_prev);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty     = (r_wptr == r_rptr);
  // Full is judged on the pre-edge pointers, so a pop on the same edge cannot rescue a push.
  assign w_push      = w_push_req && !w_full;
  assign w_baud_done = (r_baud == BAUD_MAX);
  assign w_last_char = (r_char_idx == LAST_IDX);

  assign level     = r_wptr - r_rptr;
  assign drop_cnt  = r_drop;
  assign busy      = (level != '0) || (r_state != S_IDLE);
  assign txd       = w_txd;
  assign dbg_state = r_state;

  // Current character: top nibble of the shift word as hex, then the separator(s).
  always_comb begin
    w_char = 8'h20;
    if (r_char_idx < 4'd8) begin
      w_char = (r_word[31:28] < 4'd10) ? {4'h3, r_word[31:28]}
                                       : {4'h0, r_word[31:28]} + 8'h37;
    end
`ifdef RPT_CRLF_EN
    else if (r_char_idx == 4'd8) begin
      w_char = 8'h0D;
    end else begin
      w_char = 8'h0A;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next_state = S_START;
      S_START: if (w_baud_done) w_next_state = S_DATA;
      S_DATA:  if (w_baud_done && (r_bit == 3'd7)) w_next_state = S_STOP;
      S_STOP: begin
        if (w_baud_done) begin
          if (!w_last_char || !w_empty) w_next_state = S_START;
          else                          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_txd       = 1'b1;
    w_pop       = 1'b0;
    w_next_char = 1'b0;
    case (r_state)
      S_IDLE: w_pop = !w_empty;
      S_START: w_txd = 1'b0;
      S_DATA: w_txd = w_char[r_bit];
      S_STOP: begin
        w_pop       = w_baud_done && w_last_char && !w_empty;
        w_next_char = w_baud_done && !w_last_char;
      end
      default: w_txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_drop <= '0;
    end else begin
      if (w_push_req) r_prev <= val;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push_req && w_full && (r_drop != '1)) r_drop <= r_drop + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= val;
  end

  // Baud counter restarts on every state or bit change; the bit index only advances in DATA.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud     <= '0;
      r_bit      <= '0;
      r_char_idx <= '0;
      r_word     <= '0;
    end else begin
      if ((r_state == S_IDLE) || w_baud_done) r_baud <= '0;
      else                                    r_baud <= r_baud + BW'(1);
      if (r_state != S_DATA)  r_bit <= '0;
      else if (w_baud_done)   r_bit <= r_bit + 3'd1;
      if (w_pop) begin
        r_word     <= r_mem[r_rptr[AW-1:0]];
        r_char_idx <= '0;
      end else if (w_next_char) begin
        r_word     <= {r_word[27:0], 4'h0};
        r_char_idx <= r_char_idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_result_reporter.sv
// Self-checking bench for uart_result_reporter: word-level reference model, per-cycle output
// checks and a UART receiver that compares every decoded byte with the expected text stream.
module tb_uart_result_reporter;

  localparam int CD    = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 4;
`ifdef RPT_CRLF_EN
  localparam int NCHAR = 10;
`else
  localparam int NCHAR = 9;
`endif
  localparam int WORD_CYC = NCHAR * 10 * CD;
  localparam int LIMIT    = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] val;
  logic        txd;
  logic        busy;
  logic [2:0]  level;
  logic [3:0]  drop_cnt;
  logic [1:0]  dbg_state;

  uart_result_reporter #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .DROP_W(DW)) dut (
    .clk(clk), .rst(rst), .val(val), .txd(txd), .busy(busy),
    .level(level), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: queue of pending words and cycles left in the word being sent.
  logic [31:0] m_q[$];
  logic [31:0] m_prev;
  int          m_rem;
  int          m_drops;
  logic [7:0]  m_chars [10];
  logic [7:0]  exp_q[$];
  int          lvl_peak;

  // Receiver state.
  bit          rx_active;
  int          rx_cnt;
  int          rx_n;
  logic [7:0]  rx_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? 8'd48 + 8'(n) : 8'd55 + 8'(n);
  endfunction

  function automatic logic [7:0] char_of(input logic [31:0] w, input int i);
    if (i < 8) return hex_ch(w[31-4*i -: 4]);
`ifdef RPT_CRLF_EN
    return (i == 8) ? 8'h0D : 8'h0A;
`else
    return 8'h20;
`endif
  endfunction

  function automatic logic exp_txd();
    int off, ch, b;
    if (m_rem == 0) return 1'b1;
    off = WORD_CYC - m_rem;
    ch  = off / (10 * CD);
    b   = (off / CD) % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_chars[ch][b-1];
  endfunction

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_prev    = '0;
    m_rem     = 0;
    m_drops   = 0;
    rx_active = 0;
    rx_cnt    = 0;
  endtask

  // Predicts the effect of the next rising edge given the input driven for it.
  task automatic model_edge(input logic [31:0] v);
    bit req, was_full;
    logic [31:0] w;
    req      = (v != m_prev);
    was_full = (m_q.size() == DEPTH);
    if ((m_rem <= 1) && (m_q.size() != 0)) begin
      w = m_q.pop_front();
      for (int i = 0; i < NCHAR; i++) begin
        m_chars[i] = char_of(w, i);
        exp_q.push_back(m_chars[i]);
      end
      m_rem = WORD_CYC;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    if (req) begin
      m_prev = v;
      if (was_full) begin
        if (m_drops < (1 << DW) - 1) m_drops++;
      end else begin
        m_q.push_back(v);
      end
    end
  endtask

  task automatic rx_sample();
    logic [8:0] e;
    if (!rx_active) begin
      if (txd === 1'b0) begin
        rx_active = 1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      for (int i = 0; i < 8; i++)
        if (rx_cnt == CD * (i + 1) + CD / 2) rx_byte[i] = txd;
      if (rx_cnt == CD * 9 + CD / 2) begin
        rx_active = 0;
        rx_n++;
        check("rx_stop", 32'(txd), 32'd1);
        e = (exp_q.size() != 0) ? {1'b1, exp_q.pop_front()} : 9'h000;
        check("rx_byte", 32'({1'b1, rx_byte}), 32'(e));
      end
    end
  endtask

  // One clock: check outputs at the falling edge, then drive the input for the next rising edge.
  task automatic cycle(input logic [31:0] v);
    @(negedge clk);
    check("busy", 32'(busy), 32'((m_q.size() != 0) || (m_rem != 0)));
    check("level", 32'(level), 32'(m_q.size()));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    check("txd", 32'(txd), 32'(exp_txd()));
    check("dbg_idle", 32'(dbg_state == 2'd0), 32'(m_rem == 0));
    if (32'(level) > lvl_peak) lvl_peak = 32'(level);
    rx_sample();
    val = v;
    if (!rst) model_reset();
    else      model_edge(v);
  endtask

  task automatic drain(input logic [31:0] v);
    int n;
    n = 0;
    while (((m_rem != 0) || (m_q.size() != 0)) && (n < LIMIT)) begin
      cycle(v);
      n++;
    end
    check("drain_timeout", 32'(n < LIMIT), 32'd1);
    repeat (10 * CD) cycle(v);
    check("exp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] w, v;
    int hold;
    rst = 1'b0;
    val = '0;
    rx_n = 0;
    lvl_peak = 0;
    model_reset();

    // Reset then idle with val=0: nothing is ever reported.
    repeat (3) cycle(32'h0);
    rst = 1'b1;
    repeat (100) cycle(32'h0);
    check("t1_rx_none", 32'(rx_n), 32'd0);

    // Single word, full frame timing and decode.
    cycle(32'h12345678);
    drain(32'h12345678);
    check("t2_rx_count", 32'(rx_n), 32'(NCHAR));

    // Two words back to back; only one is ever queued at a time.
    lvl_peak = 0;
    repeat (3) cycle(32'hDEADBEEF);
    cycle(32'h0000000F);
    drain(32'h0000000F);
    check("t3_peak", 32'(lvl_peak), 32'd1);

    // A change every cycle: one word in flight, FIFO fills, the rest are dropped.
    for (int i = 1; i <= 30; i++) cycle(32'(i));
    check("t4_drops", 32'(drop_cnt), 32'd15);
    drain(32'd30);

    // Asynchronous reset in the middle of a data bit of the third character.
    w = $urandom;
    if (w == 32'd30) w = 32'h12345678;
    n = 0;
    while (n < LIMIT) begin
      cycle(w);
      n++;
      if ((m_rem != 0) && (WORD_CYC - m_rem >= 2 * 10 * CD + CD) &&
          (WORD_CYC - m_rem < 2 * 10 * CD + 9 * CD) && (exp_txd() == 1'b0)) break;
    end
    check("t5_reach", 32'(n < LIMIT), 32'd1);
    @(posedge clk);
    #2;
    check("t5_pre_txd", 32'(txd), 32'd0);
    rst = 1'b0;
    model_reset();
    rx_n = 0;
    #1;
    check("t5_txd", 32'(txd), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_level", 32'(level), 32'd0);
    check("t5_drop", 32'(drop_cnt), 32'd0);
    repeat (3) cycle(32'h0);
    rst = 1'b1;
    repeat (200) cycle(32'h0);
    check("t5_rx_none", 32'(rx_n), 32'd0);

    // Push into a full FIFO on the same edge as the pop that starts the next word.
    for (int i = 1; i <= 5; i++) cycle(32'(i));
    n = 0;
    while ((m_rem != 1) && (n < LIMIT)) begin
      cycle(32'd5);
      n++;
    end
    check("t6_reach", 32'(n < LIMIT), 32'd1);
    cycle(32'd6);
    cycle(32'd6);
    check("t6_drop", 32'(drop_cnt), 32'd1);
    check("t6_level", 32'(level), 32'(DEPTH - 1));
    drain(32'd6);

    // Random changes, repeats and hold times.
    for (int k = 0; k < 40; k++) begin
      v    = ($urandom_range(0, 3) == 0) ? val : $urandom;
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 300);
      repeat (hold) cycle(v);
    end
    drain(val);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
